// File: rtl/cm0ik_ahb_dma_master.sv
// cm0ik_ahb_dma_master: AHB-Lite single-beat initiator for word copy, fill and optional check.
// Define CM0IK_DMA_CHECK_EN to enable MODE=10 (read-and-compare); otherwise MODE=10 is rejected like MODE=11.
module cm0ik_ahb_dma_master #(
  parameter int CWIDTH = 16
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              START,
  input  logic [1:0]        MODE,
  input  logic [31:0]       SRC_ADDR,
  input  logic [31:0]       DST_ADDR,
  input  logic [CWIDTH-1:0] COUNT,
  input  logic [31:0]       FILL_DATA,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic [31:0]       ERR_ADDR,
  output logic [31:0]       HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [3:0]        HPROT,
  output logic              HMASTLOCK,
  output logic [31:0]       HWDATA,
  input  logic [31:0]       HRDATA,
  input  logic              HREADY,
  input  logic              HRESP
);

  typedef enum logic [2:0] {S_IDLE, S_RD_A, S_RD_D, S_WR_A, S_WR_D, S_FIN} state_t;

  state_t            state_q, state_d;
  logic              skip_q;
  logic [1:0]        mode_q;
  logic [31:0]       src_q, src_d, dst_q, dst_d, fill_q;
  logic [CWIDTH-1:0] rem_q, rem_d;
  logic [31:0]       haddr_q, hwdata_q, err_addr_q;
  logic              err_q;
  logic              accept, mode_bad, is_fill, is_chk, chk_fail, last, rd_dst, rd_ok, wr_ok;

  assign accept  = (state_q == S_IDLE) && START;
  assign is_fill = (mode_q == 2'b01);
  assign last    = (rem_q == CWIDTH'(1));
  assign rd_ok   = (state_q == S_RD_D) && HREADY && !HRESP;
  assign wr_ok   = (state_q == S_WR_D) && HREADY && !HRESP;

`ifdef CM0IK_DMA_CHECK_EN
  assign mode_bad = (MODE == 2'b11);
  assign is_chk   = (mode_q == 2'b10);
  assign chk_fail = is_chk && (HRDATA != fill_q);
`else
  assign mode_bad = MODE[1];
  assign is_chk   = 1'b0;
  assign chk_fail = 1'b0;
`endif

  // Reads target dst in check mode; the IDLE case looks at MODE because mode_q is not loaded yet.
  assign rd_dst = accept ? (MODE == 2'b10) : is_chk;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (START) begin
        if (COUNT == '0 || mode_bad) state_d = S_FIN;
        else if (MODE == 2'b01)      state_d = S_WR_A;
        else                         state_d = S_RD_A;
      end
      S_RD_A: if (HREADY) state_d = S_RD_D;
      S_RD_D: if (HREADY) begin
        if (HRESP || chk_fail || (is_chk && last)) state_d = S_FIN;
        else if (is_chk)                           state_d = S_RD_A;
        else                                       state_d = S_WR_A;
      end
      S_WR_A: if (HREADY) state_d = S_WR_D;
      S_WR_D: if (HREADY) begin
        if (HRESP || last) state_d = S_FIN;
        else if (is_fill)  state_d = S_WR_A;
        else               state_d = S_RD_A;
      end
      // A rejected or empty request spends one extra cycle here so DONE lands two cycles after START.
      S_FIN:   if (!skip_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    HTRANS = 2'b00;
    HWRITE = 1'b0;
    DONE   = 1'b0;
    BUSY   = 1'b0;
    case (state_q)
      S_RD_A:  begin HTRANS = 2'b10; BUSY = 1'b1; end
      S_RD_D:  BUSY = 1'b1;
      S_WR_A:  begin HTRANS = 2'b10; HWRITE = 1'b1; BUSY = 1'b1; end
      S_WR_D:  begin HWRITE = 1'b1; BUSY = 1'b1; end
      S_FIN:   begin DONE = !skip_q; BUSY = skip_q; end
      default: ;
    endcase
  end

  always_comb begin
    src_d = src_q;
    dst_d = dst_q;
    rem_d = rem_q;
    if (accept) begin
      src_d = SRC_ADDR & 32'hFFFF_FFFC;
      dst_d = DST_ADDR & 32'hFFFF_FFFC;
      rem_d = COUNT;
    end else if (wr_ok || (rd_ok && is_chk)) begin
      src_d = src_q + 32'd4;
      dst_d = dst_q + 32'd4;
      rem_d = rem_q - CWIDTH'(1);
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      skip_q     <= 1'b0;
      mode_q     <= 2'b00;
      err_q      <= 1'b0;
      err_addr_q <= 32'd0;
      haddr_q    <= 32'd0;
      hwdata_q   <= 32'd0;
    end else begin
      skip_q <= accept && (COUNT == '0 || mode_bad);
      if (accept) begin
        mode_q <= MODE;
        err_q  <= mode_bad;
        if (mode_bad) err_addr_q <= DST_ADDR & 32'hFFFF_FFFC;
      end else if (((state_q == S_RD_D) || (state_q == S_WR_D)) && HRESP) begin
        err_q      <= 1'b1;
        err_addr_q <= haddr_q;
      end else if (rd_ok && chk_fail) begin
        err_q      <= 1'b1;
        err_addr_q <= haddr_q;
      end
      // HADDR only changes when entering an address phase, so it is stable across stalls.
      if (state_d != state_q && state_d == S_RD_A)      haddr_q <= rd_dst ? dst_d : src_d;
      else if (state_d != state_q && state_d == S_WR_A) haddr_q <= dst_d;
      if (state_q == S_RD_D && state_d == S_WR_A)       hwdata_q <= HRDATA;
      else if (state_d == S_WR_A && state_q != S_WR_A)  hwdata_q <= accept ? FILL_DATA : fill_q;
    end
  end

  always_ff @(posedge HCLK) begin
    src_q <= src_d;
    dst_q <= dst_d;
    rem_q <= rem_d;
    if (accept) fill_q <= FILL_DATA;
  end

  assign HADDR     = haddr_q;
  assign HWDATA    = hwdata_q;
  assign ERR       = err_q;
  assign ERR_ADDR  = err_addr_q;
  assign HSIZE     = 3'b010;
  assign HBURST    = 3'b000;
  assign HPROT     = 4'b0011;
  assign HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_cm0ik_ahb_dma_master.sv
// Scoreboard bench for cm0ik_ahb_dma_master: expected bus transfers and DONE events are queued
// by the stimulus and retired by a negedge monitor against a small reactive AHB slave.
module tb_cm0ik_ahb_dma_master;

  logic        HCLK, HRESET, START;
  logic [1:0]  MODE;
  logic [31:0] SRC_ADDR, DST_ADDR, FILL_DATA;
  logic [15:0] COUNT;
  logic        BUSY, DONE, ERR, HWRITE, HMASTLOCK;
  logic [31:0] ERR_ADDR, HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic        HREADY, HRESP;

  cm0ik_ahb_dma_master #(.CWIDTH(16)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .START(START), .MODE(MODE),
    .SRC_ADDR(SRC_ADDR), .DST_ADDR(DST_ADDR), .COUNT(COUNT), .FILL_DATA(FILL_DATA),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .ERR_ADDR(ERR_ADDR),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADY(HREADY), .HRESP(HRESP)
  );

  typedef struct {
    bit          is_done;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    bit          err;
    int          off;
  } exp_t;

  exp_t        expq[$];
  int          n_cmp = 0, n_bad = 0;
  int          cyc = 0, start_cyc = 0;
  logic [31:0] mon_wdata = 32'd0;

  // slave state and fault injection
  logic        dp_active = 1'b0, dp_write = 1'b0;
  logic [31:0] dp_addr = 32'd0;
  logic        nx_act, nx_wr, nx_new;
  logic [31:0] nx_addr;
  int          ws_left = 0, err_cnt = 0, stall_n = 0;
  bit          err_ph = 0, err_en = 0;
  logic [31:0] stall_addr = 32'd0, err_addr = 32'd0;

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc <= cyc + 1;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a >= 32'h300 && a <= 32'h30C && a != 32'h308) return 32'hF00D_F00D;
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  task automatic exp_x(input bit wr, input logic [31:0] a, input logic [31:0] d, input int off);
    exp_t e;
    e.is_done = 0; e.wr = wr; e.addr = a; e.data = d; e.err = 0; e.off = off;
    expq.push_back(e);
  endtask

  task automatic exp_done(input bit err, input logic [31:0] ea, input int off);
    exp_t e;
    e.is_done = 1; e.wr = 0; e.addr = ea; e.data = 32'd0; e.err = err; e.off = off;
    expq.push_back(e);
  endtask

  // Slave: decides the next data phase at negedge, drives HREADY/HRESP/HRDATA just after posedge.
  always begin
    @(negedge HCLK);
    nx_new = 1'b0; nx_act = dp_active; nx_wr = dp_write; nx_addr = dp_addr;
    if (HREADY) begin
      nx_act = (HTRANS == 2'b10); nx_wr = HWRITE; nx_addr = HADDR; nx_new = nx_act;
    end
    @(posedge HCLK); #1;
    if (HRESET) begin
      dp_active = 1'b0; ws_left = 0; err_ph = 0; HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'd0;
    end else begin
      dp_active = nx_act; dp_write = nx_wr; dp_addr = nx_addr;
      if (nx_new) begin
        ws_left = (stall_n > 0 && nx_addr == stall_addr) ? stall_n : 0;
        err_ph  = err_en && (nx_addr == err_addr);
        err_cnt = 0;
      end
      HRESP = 1'b0; HREADY = 1'b1; HRDATA = 32'd0;
      if (dp_active) begin
        if (!dp_write) HRDATA = mem(dp_addr);
        if (err_ph) begin
          HRESP = 1'b1; HREADY = (err_cnt != 0); err_cnt++;
        end else if (ws_left > 0) begin
          HREADY = 1'b0; ws_left--;
        end
      end
    end
  end

  // Monitor: retires queued expectations whenever the DUT issues a transfer or pulses DONE.
  always @(negedge HCLK) begin
    exp_t e;
    if (!HRESET) begin
      if (HTRANS == 2'b10 && HREADY) begin
        if (expq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_xfer: got addr 0x%08h wr %0d, required no transfer", HADDR, HWRITE);
        end else begin
          e = expq.pop_front();
          if (e.is_done) begin
            n_cmp++; n_bad++;
            $display("FAIL xfer_order: got transfer at 0x%08h, required DONE", HADDR);
          end else begin
            chk("xfer_addr", HADDR, e.addr);
            chk("xfer_write", {31'd0, HWRITE}, {31'd0, e.wr});
            chk("xfer_cycle", 32'(cyc - start_cyc), 32'(e.off));
            mon_wdata = e.data;
          end
        end
      end
      if (dp_active && dp_write) chk("hwdata", HWDATA, mon_wdata);
      if (dp_active && HRESP)    chk("htrans_in_error", {30'd0, HTRANS}, 32'd0);
      if (DONE) begin
        if (expq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_done: got DONE at cycle %0d, required none", cyc - start_cyc);
        end else begin
          e = expq.pop_front();
          if (!e.is_done) begin
            n_cmp++; n_bad++;
            $display("FAIL done_order: got DONE, required transfer at 0x%08h", e.addr);
          end else begin
            chk("done_cycle", 32'(cyc - start_cyc), 32'(e.off));
            chk("done_err", {31'd0, ERR}, {31'd0, e.err});
            chk("done_busy", {31'd0, BUSY}, 32'd0);
            if (e.err) chk("done_err_addr", ERR_ADDR, e.addr);
          end
        end
      end
    end
  end

  task automatic start_op(input logic [1:0] m, input logic [31:0] s, input logic [31:0] d,
                          input logic [15:0] c, input logic [31:0] f);
    @(posedge HCLK); #1;
    START = 1'b1; MODE = m; SRC_ADDR = s; DST_ADDR = d; COUNT = c; FILL_DATA = f;
    start_cyc = cyc;
    @(posedge HCLK); #1;
    START = 1'b0;
    chk("busy_after_start", {31'd0, BUSY}, 32'd1);
  endtask

  task automatic wait_empty(input int budget);
    int n;
    n = 0;
    while (expq.size() != 0 && n < budget) begin
      @(posedge HCLK);
      n++;
    end
    chk("queue_drained", 32'(expq.size()), 32'd0);
    expq.delete();
    repeat (2) @(posedge HCLK);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion, required finish before 100000");
    $fatal(1);
  end

  initial begin
    HRESET = 1'b1; START = 1'b0; MODE = 2'b00; SRC_ADDR = 32'd0; DST_ADDR = 32'd0;
    COUNT = 16'd0; FILL_DATA = 32'd0; HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'd0;
    repeat (3) @(posedge HCLK);
    #1 HRESET = 1'b0;
    @(negedge HCLK);
    chk("rst_busy", {31'd0, BUSY}, 32'd0);
    chk("rst_done", {31'd0, DONE}, 32'd0);
    chk("rst_err", {31'd0, ERR}, 32'd0);
    chk("rst_err_addr", ERR_ADDR, 32'd0);
    chk("rst_htrans", {30'd0, HTRANS}, 32'd0);
    chk("rst_haddr", HADDR, 32'd0);
    chk("rst_hwrite", {31'd0, HWRITE}, 32'd0);
    chk("rst_hwdata", HWDATA, 32'd0);
    chk("hsize", {29'd0, HSIZE}, 32'd2);
    chk("hburst", {29'd0, HBURST}, 32'd0);
    chk("hprot", {28'd0, HPROT}, 32'd3);
    chk("hmastlock", {31'd0, HMASTLOCK}, 32'd0);

    // copy, 3 words, zero wait
    exp_x(0, 32'h100, 0, 1);  exp_x(1, 32'h200, mem(32'h100), 3);
    exp_x(0, 32'h104, 0, 5);  exp_x(1, 32'h204, mem(32'h104), 7);
    exp_x(0, 32'h108, 0, 9);  exp_x(1, 32'h208, mem(32'h108), 11);
    exp_done(0, 0, 13);
    start_op(2'b00, 32'h100, 32'h200, 16'd3, 32'd0);
    wait_empty(60);

    // fill, 4 words, 2 wait states on the second write
    stall_addr = 32'h2000_0004; stall_n = 2;
    exp_x(1, 32'h2000_0000, 32'hA5A5_5A5A, 1); exp_x(1, 32'h2000_0004, 32'hA5A5_5A5A, 3);
    exp_x(1, 32'h2000_0008, 32'hA5A5_5A5A, 7); exp_x(1, 32'h2000_000C, 32'hA5A5_5A5A, 9);
    exp_done(0, 0, 11);
    start_op(2'b01, 32'd0, 32'h2000_0000, 16'd4, 32'hA5A5_5A5A);
    wait_empty(60);
    stall_n = 0;

    // COUNT=0
    exp_done(0, 0, 2);
    start_op(2'b00, 32'h10, 32'h20, 16'd0, 32'd0);
    wait_empty(20);

    // START while busy is ignored; low address bits dropped
    exp_x(0, 32'h400, 0, 1); exp_x(1, 32'h500, mem(32'h400), 3);
    exp_x(0, 32'h404, 0, 5); exp_x(1, 32'h504, mem(32'h404), 7);
    exp_done(0, 0, 9);
    start_op(2'b00, 32'h402, 32'h501, 16'd2, 32'd0);
    repeat (2) @(posedge HCLK);
    #1 START = 1'b1; MODE = 2'b01; DST_ADDR = 32'h900; COUNT = 16'd5; FILL_DATA = 32'h1111_1111;
    @(posedge HCLK); #1 START = 1'b0;
    wait_empty(60);

    // copy with ERROR response on the second read
    err_addr = 32'h104; err_en = 1;
    exp_x(0, 32'h100, 0, 1); exp_x(1, 32'h200, mem(32'h100), 3);
    exp_x(0, 32'h104, 0, 5);
    exp_done(1, 32'h104, 8);
    start_op(2'b00, 32'h100, 32'h200, 16'd3, 32'd0);
    wait_empty(60);
    err_en = 0;
    chk("err_sticky", {31'd0, ERR}, 32'd1);
    chk("err_addr_sticky", ERR_ADDR, 32'h104);

    // address wrap; new START also clears the sticky ERR
    exp_x(1, 32'hFFFF_FFFC, 32'h1234_5678, 1); exp_x(1, 32'h0000_0000, 32'h1234_5678, 3);
    exp_done(0, 0, 5);
    start_op(2'b01, 32'd0, 32'hFFFF_FFFC, 16'd2, 32'h1234_5678);
    wait_empty(40);

    // illegal mode
    exp_done(1, 32'h774, 2);
    start_op(2'b11, 32'h100, 32'h777, 16'd4, 32'd0);
    wait_empty(20);

    // check mode, third word wrong
`ifdef CM0IK_DMA_CHECK_EN
    exp_x(0, 32'h300, 0, 1); exp_x(0, 32'h304, 0, 3); exp_x(0, 32'h308, 0, 5);
    exp_done(1, 32'h308, 7);
`else
    exp_done(1, 32'h300, 2);
`endif
    start_op(2'b10, 32'd0, 32'h300, 16'd4, 32'hF00D_F00D);
    wait_empty(60);

    // reset in the middle of a fill
    exp_x(1, 32'h40, 32'hCAFE_0001, 1); exp_x(1, 32'h44, 32'hCAFE_0001, 3);
    start_op(2'b01, 32'd0, 32'h40, 16'd4, 32'hCAFE_0001);
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    #1 HRESET = 1'b1;
    #1;
    chk("midrst_htrans", {30'd0, HTRANS}, 32'd0);
    chk("midrst_haddr", HADDR, 32'd0);
    chk("midrst_hwdata", HWDATA, 32'd0);
    chk("midrst_hwrite", {31'd0, HWRITE}, 32'd0);
    chk("midrst_busy", {31'd0, BUSY}, 32'd0);
    chk("midrst_done", {31'd0, DONE}, 32'd0);
    chk("midrst_err", {31'd0, ERR}, 32'd0);
    chk("midrst_err_addr", ERR_ADDR, 32'd0);
    repeat (2) @(posedge HCLK);
    #1 HRESET = 1'b0;
    repeat (6) @(posedge HCLK);
    chk("midrst_queue", 32'(expq.size()), 32'd0);
    chk("midrst_idle_busy", {31'd0, BUSY}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
